seq_match_counter: RTL and testbench



---
 rtl/seq_match_counter_pkg.sv | 12 +
 rtl/seq_match_counter_match_counter.sv | 47 ++++
 rtl/seq_match_counter.sv | 99 +++++++++
 tb/tb_seq_match_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_match_counter_pkg.sv
// Shared constants and elaboration helpers for the serial pattern detector.
package seq_match_pkg;

  localparam bit MODE_MOORE = 1'b0;
  localparam bit MODE_MEALY = 1'b1;

  // Width able to hold the values 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter_match_counter.sv
// Match event counter with selectable wrap or saturate behaviour and a count-only clear.
module match_counter import seq_match_pkg::*; #(
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count: clear beats a simultaneous increment, so that event is dropped.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (inc) begin
      if (SATURATE && (cnt_r == CNT_MAX)) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/seq_match_counter.sv
// Serial pattern detector: shifts one bit per enable strobe, flags PATTERN completion
// (registered or combinational) and counts matches.
module seq_match_counter import seq_match_pkg::*; #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1011,
  parameter bit               MEALY    = MODE_MOORE,
  parameter bit               OVERLAP  = 1'b1,
  parameter int               CNT_W    = 8,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic [PAT_W-1:0] hist
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1'b1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_r;
  logic [PAT_W-1:0]  hist_nxt_s;
  logic [PAT_W-1:0]  nxt_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_nxt_s;
  logic              match_r;
  logic              match_nxt_s;
  logic              in_s;
  logic              hit_s;

  // Candidate window and completion detect; the data bit is masked while idle
  // so an undriven input cannot leak into the compare.
  always_comb begin
    if (en) begin
      in_s = in;
    end else begin
      in_s = 1'b0;
    end
    nxt_s = {hist_r[PAT_W-2:0], in_s};
    hit_s = en & (nxt_s == PATTERN) & (fill_r >= FILL_ARM);
  end

  // Next-state for history, fill level and registered match; all hold while idle.
  always_comb begin
    hist_nxt_s  = hist_r;
    fill_nxt_s  = fill_r;
    match_nxt_s = match_r;
    if (en) begin
      hist_nxt_s  = nxt_s;
      match_nxt_s = hit_s;
      // Without overlap a match consumes its bits, so the window must refill.
      if (hit_s && !OVERLAP) begin
        fill_nxt_s = FILL_ZERO;
      end else if (fill_r == FILL_FULL) begin
        fill_nxt_s = fill_r;
      end else begin
        fill_nxt_s = fill_r + FILL_ONE;
      end
    end else begin
      hist_nxt_s  = hist_r;
      fill_nxt_s  = fill_r;
      match_nxt_s = match_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r  <= {PAT_W{1'b0}};
      fill_r  <= FILL_ZERO;
      match_r <= 1'b0;
    end else begin
      hist_r  <= hist_nxt_s;
      fill_r  <= fill_nxt_s;
      match_r <= match_nxt_s;
    end
  end

  match_counter #(
    .CNT_W    (CNT_W),
    .SATURATE (SATURATE)
  ) u_match_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (hit_s),
    .cnt   (count)
  );

  assign match = (MEALY == MODE_MEALY) ? hit_s : match_r;
  assign hist  = hist_r;

endmodule

// File: tb/tb_seq_match_counter.sv
// Randomized and directed bench for seq_match_counter: six parameter variants share
// one stimulus stream and are scored against a bit-queue reference model.
module tb_seq_match_counter;

  localparam int NCFG = 6;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in;
  logic       clr;
  logic       match_w [NCFG];
  logic [7:0] count_w [NCFG];
  logic [3:0] hist_w  [NCFG];
  logic [1:0] cnt_wrap;
  logic [1:0] cnt_sat;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit raw [$];
  bit hq [NCFG][$];
  int mcount [NCFG];
  bit mmoore [NCFG];
  bit armed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults  1: no overlap  2: Mealy  3: 2-bit wrap  4: 2-bit saturate  5: pattern 0000
  seq_match_counter u_c0 (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr(clr),
                          .match(match_w[0]), .count(count_w[0]), .hist(hist_w[0]));
  seq_match_counter #(.OVERLAP(1'b0)) u_c1 (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr(clr),
                          .match(match_w[1]), .count(count_w[1]), .hist(hist_w[1]));
  seq_match_counter #(.MEALY(1'b1)) u_c2 (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr(clr),
                          .match(match_w[2]), .count(count_w[2]), .hist(hist_w[2]));
  seq_match_counter #(.CNT_W(2)) u_c3 (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr(clr),
                          .match(match_w[3]), .count(cnt_wrap), .hist(hist_w[3]));
  seq_match_counter #(.CNT_W(2), .SATURATE(1'b1)) u_c4 (.clk(clk), .rst_n(rst_n), .en(en), .in(in),
                          .clr(clr), .match(match_w[4]), .count(cnt_sat), .hist(hist_w[4]));
  seq_match_counter #(.PATTERN(4'b0000)) u_c5 (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .clr(clr),
                          .match(match_w[5]), .count(count_w[5]), .hist(hist_w[5]));

  assign count_w[3] = {6'b000000, cnt_wrap};
  assign count_w[4] = {6'b000000, cnt_sat};

  function automatic logic [3:0] cfg_pat(input int i);
    return (i == 5) ? 4'b0000 : 4'b1011;
  endfunction
  function automatic bit cfg_ovl(input int i);
    return (i != 1);
  endfunction
  function automatic bit cfg_mealy(input int i);
    return (i == 2);
  endfunction
  function automatic bit cfg_sat(input int i);
    return (i == 4);
  endfunction
  function automatic int cfg_max(input int i);
    return (i == 3 || i == 4) ? 3 : 255;
  endfunction

  // A completion needs three valid earlier bits plus the current one equal to the pattern.
  function automatic bit model_hit(input int i, input bit e, input bit b);
    int n;
    logic [3:0] w;
    if (!e) return 1'b0;
    n = hq[i].size();
    if (n < 3) return 1'b0;
    w = {hq[i][n-3], hq[i][n-2], hq[i][n-1], b};
    return (w == cfg_pat(i));
  endfunction

  function automatic logic [3:0] model_hist();
    logic [3:0] h;
    h = 4'b0000;
    foreach (raw[k]) h = {h[2:0], raw[k]};
    return h;
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, score, then advance the model at the rising edge.
  task automatic step(input bit r, input bit e, input bit b, input bit c);
    bit h [NCFG];
    rst_n = r; en = e; in = b; clr = c;
    #1;
    for (int i = 0; i < NCFG; i++) h[i] = model_hit(i, e, b);
    if (armed) begin
      for (int i = 0; i < NCFG; i++) begin
        check_val($sformatf("match%0d", i), int'(match_w[i]), cfg_mealy(i) ? int'(h[i]) : int'(mmoore[i]));
        check_val($sformatf("count%0d", i), int'(count_w[i]), mcount[i]);
        check_val($sformatf("hist%0d", i), int'(hist_w[i]), int'(model_hist()));
      end
    end
    @(posedge clk);
    if (!r) begin
      armed = 1'b1;
      raw.delete();
      for (int i = 0; i < NCFG; i++) begin
        hq[i].delete();
        mcount[i] = 0;
        mmoore[i] = 1'b0;
      end
    end else begin
      if (e) begin
        raw.push_back(b);
        if (raw.size() > 4) void'(raw.pop_front());
      end
      for (int i = 0; i < NCFG; i++) begin
        if (e) begin
          mmoore[i] = h[i];
          hq[i].push_back(b);
          if (h[i] && !cfg_ovl(i)) hq[i].delete();
          else if (hq[i].size() > 4) void'(hq[i].pop_front());
        end
        if (c) mcount[i] = 0;
        else if (h[i]) mcount[i] = (mcount[i] == cfg_max(i)) ? (cfg_sat(i) ? mcount[i] : 0) : mcount[i] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input bit b, input int idle);
    step(1'b1, 1'b1, b, 1'b0);
    repeat (idle) step(1'b1, 1'b0, 1'($urandom), 1'b0);
  endtask

  initial begin
    logic [6:0] seq;
    rst_n = 1'b0; en = 1'b0; in = 1'b0; clr = 1'b0;
    @(negedge clk);

    // reset and idle
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'($urandom), 1'b0);
    check_val("idle_count", int'(count_w[0]), 0);
    check_val("idle_hist", int'(hist_w[0]), 0);

    // 1,0,1,1,0,1,1 with three idle cycles between strobes
    seq = 7'b1011011;
    for (int k = 6; k >= 0; k--) send(seq[k], 3);
    check_val("dir_cnt_ovl", int'(count_w[0]), 2);
    check_val("dir_match_moore", int'(match_w[0]), 1);
    check_val("dir_hist", int'(hist_w[0]), 11);
    check_val("dir_cnt_novl", int'(count_w[1]), 1);
    check_val("dir_fill_novl", int'(u_c1.fill_r), 3);
    check_val("dir_cnt_mealy", int'(count_w[2]), 2);
    check_val("dir_match_mealy_idle", int'(match_w[2]), 0);

    // five overlapping matches for the counter boundaries
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 0); send(1'b0, 0); send(1'b1, 0); send(1'b1, 0);
    repeat (4) begin
      send(1'b0, 0); send(1'b1, 0); send(1'b1, 0);
    end
    check_val("wrap_count", int'(count_w[3]), 1);
    check_val("sat_count", int'(count_w[4]), 3);
    check_val("five_count", int'(count_w[0]), 5);

    // clear coinciding with a hit drops that hit
    send(1'b0, 0); send(1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("clr_hit_count", int'(count_w[0]), 0);
    check_val("clr_hit_wrap", int'(count_w[3]), 0);

    // all-zero pattern must not match the reset history
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) send(1'b0, 1);
    check_val("zero_pat_3", int'(count_w[5]), 0);
    send(1'b0, 1);
    check_val("zero_pat_4", int'(count_w[5]), 1);

    // reset in the middle of 1011
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 0); send(1'b0, 0); send(1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1);
    check_val("midrst_count", int'(count_w[0]), 0);
    check_val("midrst_match", int'(match_w[0]), 0);
    check_val("midrst_hist", int'(hist_w[0]), 1);

    // random traffic
    repeat (800) begin
      step(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
           1'($urandom), 1'($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
